// File: rtl/sum_arbiter.sv
// Two-requester round-robin sequencer in front of one shared combinational adder.
// Optional signed-overflow output enabled by defining SUM_ARB_OVF_EN.
module sum_arbiter #(
    parameter int unsigned W   = 4,
    parameter int unsigned LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    input  logic         req1,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         done0,
    output logic         done1,
    output logic [W-1:0] res,
    output logic         cout,
    output logic         ovf,
    output logic         busy,
    output logic [W-1:0] add_x,
    output logic [W-1:0] add_y,
    input  logic [W-1:0] add_o,
    input  logic         add_co
);

    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          last;
    logic          any_req_c;
    logic          winner_c;

    // Round-robin pick: a tie goes to whoever was not served last.
    always_comb begin
        any_req_c = req0 | req1;
        winner_c  = (req0 & req1) ? ~last : req1;
    end

`ifdef SUM_ARB_OVF_EN
    logic ovf_c;
    always_comb begin
        ovf_c = (add_x[W-1] == add_y[W-1]) & (add_o[W-1] != add_x[W-1]);
    end
`else
    assign ovf = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            last  <= 1'b1;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            busy  <= 1'b0;
            res   <= '0;
            cout  <= 1'b0;
            add_x <= '0;
            add_y <= '0;
`ifdef SUM_ARB_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (any_req_c) begin
                        add_x <= winner_c ? a1 : a0;
                        add_y <= winner_c ? b1 : b0;
                        gnt0  <= ~winner_c;
                        gnt1  <= winner_c;
                        busy  <= 1'b1;
                        last  <= winner_c;
                        cnt   <= CW'(LAT - 1);
                        state <= WAIT;
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        // Adder output has settled for LAT cycles; capture it.
                        res   <= add_o;
                        cout  <= add_co;
`ifdef SUM_ARB_OVF_EN
                        ovf   <= ovf_c;
`endif
                        done0 <= ~last;
                        done1 <= last;
                        gnt0  <= 1'b0;
                        gnt1  <= 1'b0;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sum_arbiter.sv
// Bench for sum_arbiter: instance 0 with LAT=1, instance 1 with LAT=3, each with its own adder.
// A transaction-level model predicts every output each cycle; directed checks pin key values.
module tb_sum_arbiter;

    localparam int unsigned W = 4;

`ifdef SUM_ARB_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic         clk;
    logic         rst_v    [2];
    logic         req0_v   [2];
    logic         req1_v   [2];
    logic [W-1:0] a0_v     [2];
    logic [W-1:0] b0_v     [2];
    logic [W-1:0] a1_v     [2];
    logic [W-1:0] b1_v     [2];
    logic         gnt0_v   [2];
    logic         gnt1_v   [2];
    logic         done0_v  [2];
    logic         done1_v  [2];
    logic [W-1:0] res_v    [2];
    logic         cout_v   [2];
    logic         ovf_v    [2];
    logic         busy_v   [2];
    logic [W-1:0] add_x_v  [2];
    logic [W-1:0] add_y_v  [2];
    logic [W-1:0] add_o_v  [2];
    logic         add_co_v [2];

    int errs   = 0;
    int checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared adders standing in for the Sum block.
    assign {add_co_v[0], add_o_v[0]} = add_x_v[0] + add_y_v[0];
    assign {add_co_v[1], add_o_v[1]} = add_x_v[1] + add_y_v[1];

    sum_arbiter #(.W(W), .LAT(1)) u_lat1 (
        .clk(clk), .rst(rst_v[0]),
        .req0(req0_v[0]), .a0(a0_v[0]), .b0(b0_v[0]),
        .req1(req1_v[0]), .a1(a1_v[0]), .b1(b1_v[0]),
        .gnt0(gnt0_v[0]), .gnt1(gnt1_v[0]), .done0(done0_v[0]), .done1(done1_v[0]),
        .res(res_v[0]), .cout(cout_v[0]), .ovf(ovf_v[0]), .busy(busy_v[0]),
        .add_x(add_x_v[0]), .add_y(add_y_v[0]), .add_o(add_o_v[0]), .add_co(add_co_v[0])
    );

    sum_arbiter #(.W(W), .LAT(3)) u_lat3 (
        .clk(clk), .rst(rst_v[1]),
        .req0(req0_v[1]), .a0(a0_v[1]), .b0(b0_v[1]),
        .req1(req1_v[1]), .a1(a1_v[1]), .b1(b1_v[1]),
        .gnt0(gnt0_v[1]), .gnt1(gnt1_v[1]), .done0(done0_v[1]), .done1(done1_v[1]),
        .res(res_v[1]), .cout(cout_v[1]), .ovf(ovf_v[1]), .busy(busy_v[1]),
        .add_x(add_x_v[1]), .add_y(add_y_v[1]), .add_o(add_o_v[1]), .add_co(add_co_v[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: an operation is in flight while m_left > 0.
    int m_left [2];
    int m_owner[2];
    int m_last [2];
    int m_a    [2];
    int m_b    [2];
    int e_gnt0 [2], e_gnt1[2], e_done0[2], e_done1[2], e_busy[2];
    int e_res  [2], e_cout[2], e_ovf[2], e_x[2], e_y[2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst_v[k]) begin
                m_left[k] = 0; m_owner[k] = 0; m_last[k] = 1; m_a[k] = 0; m_b[k] = 0;
                e_gnt0[k] = 0; e_gnt1[k] = 0; e_done0[k] = 0; e_done1[k] = 0; e_busy[k] = 0;
                e_res[k] = 0; e_cout[k] = 0; e_ovf[k] = 0; e_x[k] = 0; e_y[k] = 0;
            end else begin
                e_done0[k] = 0;
                e_done1[k] = 0;
                if (m_left[k] != 0) begin
                    m_left[k]--;
                    if (m_left[k] == 0) begin
                        int s, sa, sb;
                        s  = m_a[k] + m_b[k];
                        sa = (m_a[k] >= 8) ? m_a[k] - 16 : m_a[k];
                        sb = (m_b[k] >= 8) ? m_b[k] - 16 : m_b[k];
                        e_res[k]  = s % 16;
                        e_cout[k] = (s >= 16) ? 1 : 0;
                        e_ovf[k]  = (OVF_EN && ((sa + sb) > 7 || (sa + sb) < -8)) ? 1 : 0;
                        e_done0[k] = (m_owner[k] == 0) ? 1 : 0;
                        e_done1[k] = (m_owner[k] == 1) ? 1 : 0;
                        e_gnt0[k] = 0; e_gnt1[k] = 0; e_busy[k] = 0;
                    end
                end else if (req0_v[k] || req1_v[k]) begin
                    int w;
                    w = (req0_v[k] && req1_v[k]) ? 1 - m_last[k] : (req1_v[k] ? 1 : 0);
                    m_owner[k] = w;
                    m_last[k]  = w;
                    m_a[k]     = (w == 1) ? int'(a1_v[k]) : int'(a0_v[k]);
                    m_b[k]     = (w == 1) ? int'(b1_v[k]) : int'(b0_v[k]);
                    m_left[k]  = (k == 0) ? 1 : 3;
                    e_x[k] = m_a[k]; e_y[k] = m_b[k];
                    e_gnt0[k] = (w == 0) ? 1 : 0;
                    e_gnt1[k] = (w == 1) ? 1 : 0;
                    e_busy[k] = 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit z;
            z = rst_v[k];
            chk($sformatf("u%0d gnt0", k),  32'(gnt0_v[k]),  z ? 0 : e_gnt0[k]);
            chk($sformatf("u%0d gnt1", k),  32'(gnt1_v[k]),  z ? 0 : e_gnt1[k]);
            chk($sformatf("u%0d done0", k), 32'(done0_v[k]), z ? 0 : e_done0[k]);
            chk($sformatf("u%0d done1", k), 32'(done1_v[k]), z ? 0 : e_done1[k]);
            chk($sformatf("u%0d busy", k),  32'(busy_v[k]),  z ? 0 : e_busy[k]);
            chk($sformatf("u%0d res", k),   32'(res_v[k]),   z ? 0 : e_res[k]);
            chk($sformatf("u%0d cout", k),  32'(cout_v[k]),  z ? 0 : e_cout[k]);
            chk($sformatf("u%0d ovf", k),   32'(ovf_v[k]),   z ? 0 : e_ovf[k]);
            chk($sformatf("u%0d add_x", k), 32'(add_x_v[k]), z ? 0 : e_x[k]);
            chk($sformatf("u%0d add_y", k), 32'(add_y_v[k]), z ? 0 : e_y[k]);
            chk($sformatf("u%0d gnt excl", k),  32'(gnt0_v[k] & gnt1_v[k]), 0);
            chk($sformatf("u%0d done excl", k), 32'(done0_v[k] & done1_v[k]), 0);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst_v[k] = 1'b1; req0_v[k] = 1'b0; req1_v[k] = 1'b0;
            a0_v[k] = '0; b0_v[k] = '0; a1_v[k] = '0; b1_v[k] = '0;
        end
        repeat (3) tick();
        chk("reset last-state res", 32'(res_v[0]), 0);
        rst_v[0] = 1'b0;
        rst_v[1] = 1'b0;
        tick();

        // 3 + 4 via requester 0
        req0_v[0] = 1'b1; a0_v[0] = 4'd3; b0_v[0] = 4'd4;
        tick();
        chk("t1 gnt0", 32'(gnt0_v[0]), 1);
        chk("t1 busy", 32'(busy_v[0]), 1);
        req0_v[0] = 1'b0;
        tick();
        chk("t1 done0", 32'(done0_v[0]), 1);
        chk("t1 res", 32'(res_v[0]), 7);
        chk("t1 cout", 32'(cout_v[0]), 0);
        chk("t1 gnt0 low", 32'(gnt0_v[0]), 0);
        tick();

        // 9 + 8 via requester 1: wraps with carry and signed overflow
        req1_v[0] = 1'b1; a1_v[0] = 4'd9; b1_v[0] = 4'd8;
        tick();
        chk("t2 gnt1", 32'(gnt1_v[0]), 1);
        chk("t2 add_x", 32'(add_x_v[0]), 9);
        req1_v[0] = 1'b0;
        tick();
        chk("t2 done1", 32'(done1_v[0]), 1);
        chk("t2 res", 32'(res_v[0]), 1);
        chk("t2 cout", 32'(cout_v[0]), 1);
        chk("t2 ovf", 32'(ovf_v[0]), OVF_EN ? 1 : 0);
        tick();

        // contention: alternating grants, one completion every two cycles
        req0_v[0] = 1'b1; a0_v[0] = 4'd1; b0_v[0] = 4'd2;
        req1_v[0] = 1'b1; a1_v[0] = 4'd6; b1_v[0] = 4'd7;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("t3 gnt0 c%0d", i),  32'(gnt0_v[0]),  (i % 4 == 0) ? 1 : 0);
            chk($sformatf("t3 done0 c%0d", i), 32'(done0_v[0]), (i % 4 == 1) ? 1 : 0);
            chk($sformatf("t3 gnt1 c%0d", i),  32'(gnt1_v[0]),  (i % 4 == 2) ? 1 : 0);
            chk($sformatf("t3 done1 c%0d", i), 32'(done1_v[0]), (i % 4 == 3) ? 1 : 0);
            if (i % 4 == 3) chk($sformatf("t3 res c%0d", i), 32'(res_v[0]), 13);
        end
        req0_v[0] = 1'b0;
        req1_v[0] = 1'b0;
        tick();

        // operands and request change after grant
        req0_v[0] = 1'b1; a0_v[0] = 4'd5; b0_v[0] = 4'd5;
        tick();
        chk("t4 gnt0", 32'(gnt0_v[0]), 1);
        req0_v[0] = 1'b0; a0_v[0] = 4'd0;
        tick();
        chk("t4 done0", 32'(done0_v[0]), 1);
        chk("t4 res", 32'(res_v[0]), 10);
        chk("t4 cout", 32'(cout_v[0]), 0);
        tick();

        // LAT=3: 15 + 1
        req1_v[1] = 1'b1; a1_v[1] = 4'd15; b1_v[1] = 4'd1;
        tick();
        chk("t5 gnt1", 32'(gnt1_v[1]), 1);
        chk("t5 busy c0", 32'(busy_v[1]), 1);
        req1_v[1] = 1'b0;
        for (int i = 1; i < 3; i++) begin
            tick();
            chk($sformatf("t5 busy c%0d", i), 32'(busy_v[1]), 1);
            chk($sformatf("t5 done1 early c%0d", i), 32'(done1_v[1]), 0);
        end
        tick();
        chk("t5 done1", 32'(done1_v[1]), 1);
        chk("t5 res", 32'(res_v[1]), 0);
        chk("t5 cout", 32'(cout_v[1]), 1);
        chk("t5 busy low", 32'(busy_v[1]), 0);
        tick();

        // reset in the middle of a LAT=3 operation
        req0_v[1] = 1'b1; a0_v[1] = 4'd2; b0_v[1] = 4'd2;
        tick();
        chk("t6 gnt0", 32'(gnt0_v[1]), 1);
        req0_v[1] = 1'b0;
        tick();
        #1 rst_v[1] = 1'b1;
        #1;
        chk("t6 rst gnt0", 32'(gnt0_v[1]), 0);
        chk("t6 rst busy", 32'(busy_v[1]), 0);
        chk("t6 rst add_x", 32'(add_x_v[1]), 0);
        chk("t6 rst cout", 32'(cout_v[1]), 0);
        req0_v[1] = 1'b1; a0_v[1] = 4'd2; b0_v[1] = 4'd3;
        req1_v[1] = 1'b1; a1_v[1] = 4'd4; b1_v[1] = 4'd4;
        tick();
        chk("t6 no done", 32'(done0_v[1]), 0);
        rst_v[1] = 1'b0;
        tick();
        chk("t6 tie gnt0", 32'(gnt0_v[1]), 1);
        chk("t6 tie gnt1", 32'(gnt1_v[1]), 0);
        chk("t6 tie add_x", 32'(add_x_v[1]), 2);
        req0_v[1] = 1'b0;
        req1_v[1] = 1'b0;
        repeat (3) tick();
        chk("t6 done0", 32'(done0_v[1]), 1);
        chk("t6 res", 32'(res_v[1]), 5);
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
